// File: rtl/spi_req_arbiter_if.sv
// spi_req_arbiter_if: requester-side request/response bundle of spi_req_arbiter.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      busy;
    modport master (output req_valid, req_wdata, input req_ready, rsp_valid, rsp_rdata, busy);
    modport slave  (input req_valid, req_wdata, output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: round-robin sharing of one SPI mode-0 master port among NUM_REQ requesters.
// Define SPI_REQ_ARBITER_STATS_EN to add per-requester saturating completion counters (txn_cnt).
module spi_req_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    spi_req_arbiter_if.slave  bus,
    output logic              spi_sclk,
    output logic              spi_cs_l,
    output logic              spi_mosi,
    input  logic              spi_miso
`ifdef SPI_REQ_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0] txn_cnt
`endif
);
    localparam int GW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(DATA_W + 1);
    localparam int CW = $clog2(CLK_DIV + CS_SETUP + CS_HOLD + 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [DATA_W-1:0] tx_sr, rx_sr, wsel;
    logic [GW-1:0]     last_grant, gnt_idx;
    logic              gnt_any;

    // The lowest valid index is the wrap-around winner; any valid index above last_grant beats it.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                gnt_any = 1'b1;
                gnt_idx = GW'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req_valid[i] && GW'(i) > last_grant) gnt_idx = GW'(i);
        wsel = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
        bus.req_ready = (state == IDLE && gnt_any) ? NUM_REQ'(1) << gnt_idx : '0;
    end

    // tx_sr is all zeros once every bit has been shifted out, so mosi idles low.
    assign spi_mosi = tx_sr[DATA_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            tx_sr         <= '0;
            rx_sr         <= '0;
            last_grant    <= GW'(NUM_REQ - 1);
            bus.rsp_valid <= '0;
            bus.rsp_rdata <= '0;
            bus.busy      <= 1'b0;
            spi_sclk      <= 1'b0;
            spi_cs_l      <= 1'b1;
        end else begin
            bus.rsp_valid <= '0;
            case (state)
                IDLE: if (gnt_any) begin
                    state      <= SETUP;
                    cnt        <= '0;
                    tx_sr      <= wsel;
                    last_grant <= gnt_idx;
                    bus.busy   <= 1'b1;
                    spi_cs_l   <= 1'b0;
                end
                SETUP: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        state   <= SHIFT;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt      <= '0;
                        spi_sclk <= !spi_sclk;
                        if (!spi_sclk) rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
                        else begin
                            tx_sr   <= tx_sr << 1;
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == BW'(DATA_W - 1)) state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        state         <= DONE;
                        spi_cs_l      <= 1'b1;
                        bus.rsp_valid <= NUM_REQ'(1) << last_grant;
                        bus.rsp_rdata <= rx_sr;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_REQ_ARBITER_STATS_EN
    always_ff @(posedge clk)
        for (int i = 0; i < NUM_REQ; i++)
            if (!rst_n) txn_cnt[i*16 +: 16] <= '0;
            else if (bus.rsp_valid[i] && txn_cnt[i*16 +: 16] != 16'hFFFF)
                txn_cnt[i*16 +: 16] <= txn_cnt[i*16 +: 16] + 16'd1;
`endif
endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
- Shares the single board SPI master port (sclk/cs_l/mosi/miso) between NUM_REQ on-chip requesters, e.g. the host CSR bridge and the telemetry poller.
- Round-robin arbitration, then one full-duplex DATA_W-bit SPI mode-0 transfer per grant.
- Sits between the FME/BMC-side requesters and the top-level SPI pins.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- DATA_W, 32, bits per transfer, MSB first (>=2).
- CLK_DIV, 4, clk cycles per sclk half-period (>=1).
- CS_SETUP, 2, clk cycles cs_l low before the first sclk rise (>=1).
- CS_HOLD, 2, clk cycles after the last sclk fall before cs_l rises (>=1).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data; slice i belongs to requester i.
- req_ready  out  NUM_REQ  one-hot accept strobe.
- rsp_valid  out  NUM_REQ  one-hot, 1-cycle completion strobe.
- rsp_rdata  out  DATA_W  shared read data; valid when any rsp_valid is high.
- busy  out  1  high from accept through DONE.
- spi_sclk  out  1  SPI clock, idles low.
- spi_cs_l  out  1  chip select, active low, idles high.
- spi_mosi  out  1  serial out.
- spi_miso  in  1  serial in.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, spi_sclk=0, spi_cs_l=1, spi_mosi=0. The RR pointer is reset so requester 0 has top priority.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - If any req_valid is high, grant the first requester at or after (last_grant+1) mod NUM_REQ.
  - req_ready[g] is high combinationally in that same cycle (cycle T).
  - req_wdata slice g is captured into tx_sr; last_grant<=g; go to SETUP.
  - req_ready is never high outside IDLE.
  - A requester that drops valid before grant is simply skipped; no state is kept.
- SETUP:
  - cs_l=0, sclk=0, mosi=tx_sr[MSB].
  - Lasts CS_SETUP cycles, then SHIFT.
- SHIFT, mode 0:
  - The divider counts CLK_DIV cycles per half-period; sclk toggles at each terminal count.
  - On the cycle sclk is driven high, spi_miso is sampled into rx_sr LSB, shifting left.
  - On the cycle sclk is driven low, tx_sr shifts left and mosi shows the next bit.
  - A bit counter (width clog2(DATA_W+1)) ends SHIFT after the DATA_W-th fall.
  - SHIFT lasts exactly 2*CLK_DIV*DATA_W cycles.
- HOLD: sclk=0, cs_l=0 for CS_HOLD cycles.
- DONE (1 cycle):
  - cs_l=1, rsp_valid[g]=1, rsp_rdata=rx_sr.
  - rsp_rdata holds its value until the next DONE.
  - Return to IDLE.
- Latency: rsp_valid is high at T+1+CS_SETUP+2*CLK_DIV*DATA_W+CS_HOLD. With defaults this is T+261.
- Back-to-back:
  - Earliest next accept is the cycle after DONE.
  - Minimum cs_l high time between transfers is 2 cycles (DONE + IDLE).
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- busy=1 in SETUP, SHIFT, HOLD and DONE; 0 in IDLE.
- Reset mid-transfer:
  - At the first rising clk with rst_n=0, all outputs return to reset values and the FSM goes to IDLE.
  - The transfer is dropped; no rsp_valid is issued for it.
- All outputs are registered except req_ready.

Optional Feature:
- Macro SPI_REQ_ARBITER_STATS_EN.
- When defined:
  - Adds output txn_cnt [NUM_REQ*16]: one 16-bit count per requester of completed transfers.
  - Increments on rsp_valid[i]; saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: the port and counters do not exist; all other behaviour is identical.

Test Plan:
- Loopback mosi->miso, defaults, req_valid[0] with wdata 32'hA5C3_0F96 -> req_ready[0] at T, rsp_valid[0] at T+261, rsp_rdata=32'hA5C3_0F96. Check 32 sclk rises, cs_l low T+1..T+260, sclk low at the cs_l edges.
- Both requesters valid continuously with wdata 32'h1111_1111 / 32'h2222_2222 for 4 transfers -> grant order 0,1,0,1; each rsp_valid only on the granted index with matching rdata; cs_l high for exactly 2 cycles between transfers.
- miso tied 1, req 1 valid -> rsp_rdata=32'hFFFF_FFFF. Then miso tied 0 -> 32'h0000_0000.
- Mode-0 timing, CLK_DIV=1, DATA_W=8, wdata 8'h81 -> sclk period 2 clk; mosi stable across every sclk rise; mosi=1 for bits 7 and 0 only; rsp_valid at T+1+2+16+2=T+21.
- rst_n pulsed low for 1 cycle at T+100 of a transfer -> cs_l=1, sclk=0, busy=0 next cycle; no rsp_valid. A new request is accepted with requester 0 priority.
- SPI_REQ_ARBITER_STATS_EN defined, 3 transfers on req 0 and 1 on req 1 -> txn_cnt = {16'd1, 16'd3}. Preloaded counter at 16'hFFFF stays at 16'hFFFF after another completion.
